// File: rtl/instr_load_ctrl_pkg.sv
// Shared definitions for the instruction loader: default word width and
// FSM state encodings. Optional checksum feature: LOAD_CHKSUM_EN.
`ifndef IWIDTH
`define IWIDTH 32
`endif

package instr_load_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } load_state_e;

endpackage

// File: rtl/instr_load_ctrl_timer.sv
// load_timer: idle-cycle counter used while receiving. It counts enabled
// cycles, clears on clr (clr wins), and flags when it sits one step below
// TIMEOUT-1, so the enabled cycle that would reach TIMEOUT-1 raises the error.
module load_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic l_clk,
  input  logic l_rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // next count: clear has priority over counting
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + TW'(1);
  end

  // counter register
  always_ff @(posedge l_clk or negedge l_rst) begin
    if (!l_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == TW'(TIMEOUT - 2));

endmodule

// File: rtl/instr_load_ctrl.sv
// instr_load_ctrl: receives instruction words from a transmitter and writes
// them into instruction memory with one cycle of latency. All outputs are
// registered. Define LOAD_CHKSUM_EN to add l_o_chksum (XOR of written words).
`ifndef IWIDTH
`define IWIDTH 32
`endif

module instr_load_ctrl
  import instr_load_ctrl_pkg::*;
#(
  parameter int IWIDTH  = `IWIDTH,
  parameter int AWIDTH  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              l_clk,
  input  logic              l_rst,
  input  logic              l_i_start,
  output logic              l_o_syn,
  input  logic [IWIDTH-1:0] l_i_instr,
  input  logic              l_i_last,
  input  logic              l_i_ack,
  output logic              l_o_we,
  output logic [AWIDTH-1:0] l_o_addr,
  output logic [IWIDTH-1:0] l_o_wdata,
  output logic              l_o_busy,
  output logic              l_o_done,
  output logic              l_o_err,
  output logic [AWIDTH:0]   l_o_count
`ifdef LOAD_CHKSUM_EN
  ,
  output logic [IWIDTH-1:0] l_o_chksum
`endif
);

  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(1 << AWIDTH);

  load_state_e       state_q, state_d;
  logic              syn_q, syn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [IWIDTH-1:0] wdata_q, wdata_d;
  logic [AWIDTH:0]   count_q, count_d;
`ifdef LOAD_CHKSUM_EN
  logic [IWIDTH-1:0] chk_q, chk_d;
`endif

  logic tmr_clr, tmr_en, tmr_at_limit;

  load_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .l_clk  (l_clk),
    .l_rst  (l_rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_at_limit)
  );

  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    syn_d   = syn_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
`ifdef LOAD_CHKSUM_EN
    chk_d   = chk_q;
`endif
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (l_i_start) begin
          state_d = S_RECV;
          syn_d   = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          count_d = '0;
          tmr_clr = 1'b1;
`ifdef LOAD_CHKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      S_RECV: begin
        if (l_i_ack) begin
          tmr_clr = 1'b1;
          if (count_q == DEPTH_C) begin
            // memory full and no last flag seen: drop the word
            state_d = S_ERR;
            syn_d   = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = count_q[AWIDTH-1:0];
            wdata_d = l_i_instr;
            count_d = count_q + (AWIDTH + 1)'(1);
`ifdef LOAD_CHKSUM_EN
            chk_d   = chk_q ^ l_i_instr;
`endif
            if (l_i_last) begin
              state_d = S_DONE;
              syn_d   = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end else begin
          tmr_en = 1'b1;
          if (tmr_at_limit) begin
            state_d = S_ERR;
            syn_d   = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge l_clk or negedge l_rst) begin
    if (!l_rst) begin
      state_q <= S_IDLE;
      syn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
`ifdef LOAD_CHKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      syn_q   <= syn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
`ifdef LOAD_CHKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign l_o_syn   = syn_q;
  assign l_o_busy  = busy_q;
  assign l_o_done  = done_q;
  assign l_o_err   = err_q;
  assign l_o_we    = we_q;
  assign l_o_addr  = addr_q;
  assign l_o_wdata = wdata_q;
  assign l_o_count = count_q;
`ifdef LOAD_CHKSUM_EN
  assign l_o_chksum = chk_q;
`endif

endmodule

// File: tb/tb_instr_load_ctrl.sv
// Directed bench for instr_load_ctrl: a default instance (AWIDTH=5) and a
// small instance (AWIDTH=2) for the memory-full case. Inputs are driven and
// outputs sampled 1ns after the rising edge.
`timescale 1ns/1ps
module tb_instr_load_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, start_s = 1'b0;
  logic [31:0] instr = '0;
  logic        last = 1'b0, ack = 1'b0;

  logic        syn, we, busy, done, err;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [5:0]  count;
  logic        syn_s, we_s, busy_s, done_s, err_s;
  logic [1:0]  addr_s;
  logic [31:0] wdata_s;
  logic [2:0]  count_s;
`ifdef LOAD_CHKSUM_EN
  logic [31:0] chksum, chksum_s;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  instr_load_ctrl #(.IWIDTH(32), .AWIDTH(5), .TIMEOUT(16)) u_dut (
    .l_clk(clk), .l_rst(rst), .l_i_start(start), .l_o_syn(syn),
    .l_i_instr(instr), .l_i_last(last), .l_i_ack(ack),
    .l_o_we(we), .l_o_addr(addr), .l_o_wdata(wdata),
    .l_o_busy(busy), .l_o_done(done), .l_o_err(err), .l_o_count(count)
`ifdef LOAD_CHKSUM_EN
    , .l_o_chksum(chksum)
`endif
  );

  instr_load_ctrl #(.IWIDTH(32), .AWIDTH(2), .TIMEOUT(16)) u_dut_s (
    .l_clk(clk), .l_rst(rst), .l_i_start(start_s), .l_o_syn(syn_s),
    .l_i_instr(instr), .l_i_last(last), .l_i_ack(ack),
    .l_o_we(we_s), .l_o_addr(addr_s), .l_o_wdata(wdata_s),
    .l_o_busy(busy_s), .l_o_done(done_s), .l_o_err(err_s), .l_o_count(count_s)
`ifdef LOAD_CHKSUM_EN
    , .l_o_chksum(chksum_s)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic l);
    instr = w; last = l; ack = 1'b1; step(); ack = 1'b0; last = 1'b0;
  endtask

  logic [31:0] words [3];
  logic        we_seen;

  initial begin
    words[0] = 32'h2008_0005;
    words[1] = 32'h2009_0003;
    words[2] = 32'h0109_5020;

    // reset state
    step(); step();
    chk("rst_syn", syn, 0);   chk("rst_we", we, 0);     chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0);   chk("rst_count", count, 0);
    rst = 1'b1;
    step();

    // basic three-word load
    do_start();
    chk("b_syn", syn, 1); chk("b_busy", busy, 1); chk("b_we0", we, 0);
    for (int i = 0; i < 3; i++) begin
      send(words[i], i == 2);
      chk($sformatf("b_we%0d", i), we, 1);
      chk($sformatf("b_addr%0d", i), addr, i);
      chk($sformatf("b_wdata%0d", i), wdata, words[i]);
    end
    chk("b_done", done, 1); chk("b_count", count, 3); chk("b_syn_end", syn, 0);
    chk("b_busy_end", busy, 0);
    step();
    chk("b_we_after", we, 0); chk("b_done_hold", done, 1);
    // ack outside RECV is ignored
    send(32'hDEAD_BEEF, 1'b0);
    chk("b_idle_ack_we", we, 0); chk("b_idle_ack_cnt", count, 3);

    // alternate-cycle acks with gaps
    do_start();
    chk("g_done_clr", done, 0); chk("g_count_clr", count, 0);
    for (int i = 0; i < 4; i++) begin
      send(32'h1000 + i, i == 3);
      chk($sformatf("g_we%0d", i), we, 1);
      chk($sformatf("g_addr%0d", i), addr, i);
      if (i < 3) begin
        step();
        chk($sformatf("g_gap%0d", i), we, 0);
      end
    end
    chk("g_count", count, 4); chk("g_done", done, 1); chk("g_err", err, 0);

    // timeout with no acks
    do_start();
    we_seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      we_seen |= we;
    end
    chk("t_err_early", err, 0); chk("t_syn_early", syn, 1);
    step(); we_seen |= we;
    chk("t_err", err, 1); chk("t_syn", syn, 0); chk("t_busy", busy, 0);
    chk("t_we_never", we_seen, 0); chk("t_count", count, 0);

    // memory full on the small instance
    start_s = 1'b1; step(); start_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'hA0 + i, 1'b0);
      chk($sformatf("f_we%0d", i), we_s, 1);
      chk($sformatf("f_addr%0d", i), addr_s, i);
    end
    send(32'hA4, 1'b0);
    chk("f_we5", we_s, 0); chk("f_err", err_s, 1); chk("f_count", count_s, 4);
    chk("f_syn", syn_s, 0); chk("f_done", done_s, 0);

    // reset mid-load, then restart
    do_start();
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    instr = 32'h33; ack = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("r_syn", syn, 0); chk("r_we", we, 0); chk("r_addr", addr, 0);
    chk("r_wdata", wdata, 0); chk("r_busy", busy, 0); chk("r_count", count, 0);
    step();
    chk("r_we_hold", we, 0);
    rst = 1'b1; ack = 1'b0;
    step();
    send(32'h44, 1'b0);
    chk("r_no_resume", we, 0); chk("r_idle_busy", busy, 0);
    do_start();
    send(32'h55, 1'b0);
    send(32'h66, 1'b1);
    chk("r2_wdata", wdata, 32'h66); chk("r2_addr", addr, 1);
    chk("r2_count", count, 2); chk("r2_done", done, 1);

`ifdef LOAD_CHKSUM_EN
    // checksum of written words
    do_start();
    chk("c_clr", chksum, 0);
    send(32'h0000_FFFF, 1'b0);
    send(32'hFFFF_0000, 1'b0);
    send(32'h1234_5678, 1'b1);
    chk("c_sum", chksum, 32'hEDCB_A987);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_load_ctrl.md
INSTR_LOAD_CTRL -- requirements
Module: instr_load_ctrl

Interface
REQ-001 SHALL have parameter IWIDTH, default `IWIDTH (32): instruction word width.
REQ-002 SHALL have parameter AWIDTH, default 5: instruction-memory address width, DEPTH = 2**AWIDTH.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum idle cycles between acks while receiving.
REQ-004 SHALL have port l_clk  in  1  the single clock, rising edge.
REQ-005 SHALL have port l_rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port l_i_start  in  1  one-cycle load request.
REQ-007 SHALL have port l_o_syn  out  1  sync/request to the transmitter.
REQ-008 SHALL have port l_i_instr  in  IWIDTH  word from the transmitter.
REQ-009 SHALL have port l_i_last  in  1  final-word flag, qualified by l_i_ack.
REQ-010 SHALL have port l_i_ack  in  1  word-valid strobe from the transmitter.
REQ-011 SHALL have ports l_o_we (1), l_o_addr (AWIDTH), l_o_wdata (IWIDTH), all out: instruction-memory write port.
REQ-012 SHALL have ports l_o_busy, l_o_done, l_o_err (each out, 1): status.
REQ-013 SHALL have port l_o_count  out  AWIDTH+1  words written in the current load.

Function
REQ-014 SHALL implement FSM states IDLE, RECV, DONE, ERR; all outputs registered.
REQ-015 IDLE/DONE/ERR + l_i_start: next edge -> RECV; count, timeout counter and checksum cleared; l_o_syn=1.
REQ-016 l_i_start in RECV SHALL be ignored.
REQ-017 In RECV, l_o_syn=1, l_o_busy=1; each cycle with l_i_ack=1 accepts one word.
REQ-018 Accepted word SHALL appear on the next cycle as l_o_we=1, l_o_addr=count before increment, l_o_wdata=l_i_instr (latency 1); count+1 on the same edge.
REQ-019 l_o_we SHALL be 0 in every cycle not directly following an accepted word.
REQ-020 Accepted word with l_i_last=1: next state DONE, l_o_syn=0, l_o_done=1 (held until restart).
REQ-021 Ack with count==DEPTH (memory full, no last seen): word not written, next state ERR.
REQ-022 Word accepted into slot DEPTH-1 with l_i_last=1 SHALL be legal and end in DONE.
REQ-023 Timeout counter increments each RECV cycle without ack, clears on ack; reaching TIMEOUT-1 without ack -> ERR.
REQ-024 ERR: l_o_syn=0, l_o_busy=0, l_o_err=1 held until restart; count retains its value.
REQ-025 l_i_ack outside RECV SHALL be ignored.

Reset
REQ-026 l_rst=0 SHALL asynchronously force IDLE, l_o_syn=0, l_o_we=0, l_o_addr=0, l_o_wdata=0, l_o_busy=0, l_o_done=0, l_o_err=0, l_o_count=0, checksum=0.
REQ-027 Reset mid-RECV SHALL abort the load with no further writes; operation resumes only on a new l_i_start after l_rst=1.

Configuration
REQ-028 Macro LOAD_CHKSUM_EN defined: extra port l_o_chksum out IWIDTH, XOR of all written words, updated with l_o_we, cleared on start/reset.
REQ-029 Macro undefined: port and checksum logic absent; other behaviour identical.

Structure
REQ-030 FSM state encodings and the IWIDTH default SHALL live in the shared definitions header with the existing `IWIDTH.
REQ-031 Timeout counter SHALL be a sub-module load_timer (clear, enable, expire outputs).

Verification
REQ-032 Reset 2 cycles, start, ack words 0x20080005, 0x20090003, 0x01095020 (last on third) -> writes addr 0,1,2 one cycle after each ack, done=1, count=3, syn=0.
REQ-033 Acks on alternate cycles with 3 gaps -> no timeout, writes only after acks, count correct.
REQ-034 Start then no ack for 15 cycles (TIMEOUT=16) -> err=1, syn=0, we never asserted.
REQ-035 AWIDTH=2, 5 acks without last -> 4 writes (addr 0..3), 5th not written, err=1, count=4.
REQ-036 Reset asserted after 2nd word of 4 -> all outputs 0 immediately; restart and load 2 words -> count=2, done=1.
REQ-037 LOAD_CHKSUM_EN, words 0x0000FFFF, 0xFFFF0000, 0x12345678 -> l_o_chksum=0xEDCBA987.
